// File: rtl/traffic_phase_sched.sv
// Demand-driven main/country phase scheduler, all timing in TICK units.
// Optional EMERGENCY_PREEMPT_EN adds EMERG_REQ preemption toward main.
module traffic_phase_sched #(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 12,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       TICK,
  input  logic [2:0] MAIN_TRAFFIC,
  input  logic [2:0] COUNTRY_TRAFFIC,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       EMERG_REQ,
`endif
  output logic [1:0] MAINLIGHT,
  output logic [1:0] COUNTRYLIGHT,
  output logic [2:0] PHASE
);

  localparam int TW = $clog2(MAX_GREEN + 1);

  localparam logic [TW:0]   ONE_E = (TW+1)'(1);
  localparam logic [TW:0]   MIN_E = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0]   MAX_E = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0]   YEL_E = (TW+1)'(YELLOW_TICKS);
  localparam logic [TW:0]   AR_E  = (TW+1)'(ALLRED_TICKS);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN);

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  typedef enum logic [2:0] {
    M_GRN  = 3'd0,
    M_YEL  = 3'd1,
    AR_M2C = 3'd2,
    C_GRN  = 3'd3,
    C_YEL  = 3'd4,
    AR_C2M = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic [TW:0]     e;
  logic [2:0]      m_q;
  logic [2:0]      c_q;
  logic            emerg_q;
  logic [1:0]      main_d;
  logic [1:0]      country_d;

  logic c_dem;
  logic c_wins;
  logic m_wins;
  logic min_ok;
  logic max_hit;

`ifdef EMERGENCY_PREEMPT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      emerg_q <= 1'b0;
    end else begin
      emerg_q <= EMERG_REQ;
    end
  end
`else
  assign emerg_q = 1'b0;
`endif

  assign e       = {1'b0, timer_q} + ONE_E;
  assign c_dem   = (c_q != 3'd0);
  assign c_wins  = (c_q > m_q);
  assign m_wins  = (m_q >= c_q) && (m_q != 3'd0);
  assign min_ok  = (e >= MIN_E);
  assign max_hit = (e >= MAX_E);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (TICK) begin
      timer_d = (e > MAX_E) ? MAX_T : e[TW-1:0];
      unique case (state_q)
        M_GRN: begin
          if (!emerg_q && c_dem &&
              ((min_ok && c_wins) || max_hit))
            state_d = M_YEL;
        end
        M_YEL: begin
          if (e == YEL_E) state_d = AR_M2C;
        end
        AR_M2C: begin
          if (emerg_q)          state_d = AR_C2M;
          else if (e == AR_E)   state_d = C_GRN;
        end
        C_GRN: begin
          if (emerg_q ||
              (min_ok && (!c_dem || m_wins || max_hit)))
            state_d = C_YEL;
        end
        C_YEL: begin
          if (e == YEL_E) state_d = AR_C2M;
        end
        AR_C2M: begin
          if (e == AR_E) state_d = M_GRN;
        end
        default: state_d = AR_C2M;
      endcase
      if (state_d != state_q) timer_d = '0;
    end
  end

  // lights are decoded from the next state so they switch with it
  always_comb begin
    main_d    = L_RED;
    country_d = L_RED;
    unique case (1'b1)
      (state_d == M_GRN): main_d    = L_GRN;
      (state_d == M_YEL): main_d    = L_YEL;
      (state_d == C_GRN): country_d = L_GRN;
      (state_d == C_YEL): country_d = L_YEL;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= AR_C2M;
      timer_q      <= '0;
      m_q          <= 3'd0;
      c_q          <= 3'd0;
      MAINLIGHT    <= L_RED;
      COUNTRYLIGHT <= L_RED;
      PHASE        <= 3'd5;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      m_q          <= MAIN_TRAFFIC;
      c_q          <= COUNTRY_TRAFFIC;
      MAINLIGHT    <= main_d;
      COUNTRYLIGHT <= country_d;
      PHASE        <= state_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched with a cycle scoreboard
// and per-cycle light safety checks.
module tb_traffic_phase_sched;

  localparam int MIN = 4;
  localparam int MAX = 12;
  localparam int YEL = 2;
  localparam int AR  = 1;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b1;
  logic       TICK = 1'b1;
  logic [2:0] MAIN_TRAFFIC = 3'd0;
  logic [2:0] COUNTRY_TRAFFIC = 3'd0;
  logic [1:0] MAINLIGHT;
  logic [1:0] COUNTRYLIGHT;
  logic [2:0] PHASE;
`ifdef EMERGENCY_PREEMPT_EN
  logic       EMERG_REQ = 1'b0;
`endif

  traffic_phase_sched dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .TICK(TICK),
    .MAIN_TRAFFIC(MAIN_TRAFFIC),
    .COUNTRY_TRAFFIC(COUNTRY_TRAFFIC),
`ifdef EMERGENCY_PREEMPT_EN
    .EMERG_REQ(EMERG_REQ),
`endif
    .MAINLIGHT(MAINLIGHT),
    .COUNTRYLIGHT(COUNTRYLIGHT),
    .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit gated = 1'b0;

  int ms, mt, mm, mc;
  logic [1:0] pm, pc;
  int ar_run;
  logic [6:0] sb[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lights(int s);
    case (s)
      0: return 4'b1000;
      1: return 4'b0100;
      3: return 4'b0010;
      4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic step();
    int el, nx;
    logic [6:0] got, want;
    logic ok;
    TICK = gated ? (cyc % 3 == 0) : 1'b1;
    cyc++;
    if (TICK) begin
      el = mt + 1;
      nx = ms;
      case (ms)
        0: if (mc != 0 && ((el >= MIN && mc > mm) || el >= MAX)) nx = 1;
        1: if (el == YEL) nx = 2;
        2: if (el == AR) nx = 3;
        3: if (el >= MIN &&
               (mc == 0 || (mm >= mc && mm != 0) || el >= MAX)) nx = 4;
        4: if (el == YEL) nx = 5;
        default: if (el == AR) nx = 0;
      endcase
      mt = (nx != ms) ? 0 : ((el > MAX) ? MAX : el);
      ms = nx;
    end
    mm = int'(MAIN_TRAFFIC);
    mc = int'(COUNTRY_TRAFFIC);
    sb.push_back({3'(ms), lights(ms)});
    @(posedge CLK);
    #1;
    got  = {PHASE, MAINLIGHT, COUNTRYLIGHT};
    want = sb.pop_front();
    check("cycle", got, want);
    ok = 1'b1;
    if (MAINLIGHT == 2'b10 && COUNTRYLIGHT == 2'b10) ok = 1'b0;
    if (MAINLIGHT == 2'b11 || COUNTRYLIGHT == 2'b11) ok = 1'b0;
    if (pm == 2'b10 && MAINLIGHT == 2'b00) ok = 1'b0;
    if (pc == 2'b10 && COUNTRYLIGHT == 2'b00) ok = 1'b0;
    if ((MAINLIGHT == 2'b10 && pm != 2'b10) ||
        (COUNTRYLIGHT == 2'b10 && pc != 2'b10)) begin
      if (pm != 2'b00 || pc != 2'b00 || ar_run < AR) ok = 1'b0;
    end
    if (MAINLIGHT == 2'b00 && COUNTRYLIGHT == 2'b00) ar_run++;
    else ar_run = 0;
    check("safety", ok, 1);
    pm = MAINLIGHT;
    pc = COUNTRYLIGHT;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #1;
    ms = 5; mt = 0; mm = 0; mc = 0;
    sb.delete();
    check("reset", {PHASE, MAINLIGHT, COUNTRYLIGHT}, {3'd5, 4'd0});
    pm = 2'b00;
    pc = 2'b00;
    ar_run = AR;
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic run_phase(input logic [2:0] ph, output int n);
    int g;
    n = 0;
    g = 0;
    while (PHASE != ph && g < 500) begin
      step();
      g++;
    end
    while (PHASE == ph && g < 500) begin
      n++;
      step();
      g++;
    end
  endtask

  initial begin
    int n;
    #2;
    do_reset();

    MAIN_TRAFFIC = 3'd2;
    COUNTRY_TRAFFIC = 3'd0;
    step();
    check("idle_first_green", MAINLIGHT, 2'b10);
    repeat (200) step();
    check("idle_hold", {PHASE, MAINLIGHT}, {3'd0, 2'b10});

    #2;
    do_reset();
    MAIN_TRAFFIC = 3'd2;
    COUNTRY_TRAFFIC = 3'd5;
    run_phase(3'd0, n);
    check("m_min_green", n, MIN);
    run_phase(3'd1, n);
    check("m_yellow", n, YEL);
    run_phase(3'd2, n);
    check("ar_m2c", n, AR);
    run_phase(3'd3, n);
    check("c_max_green", n, MAX);
    run_phase(3'd4, n);
    check("c_yellow", n, YEL);

    #2;
    do_reset();
    MAIN_TRAFFIC = 3'd6;
    COUNTRY_TRAFFIC = 3'd1;
    run_phase(3'd0, n);
    check("m_max_green", n, MAX);
    run_phase(3'd3, n);
    check("c_min_green", n, MIN);

    #2;
    do_reset();
    gated = 1'b1;
    MAIN_TRAFFIC = 3'd2;
    COUNTRY_TRAFFIC = 3'd5;
    run_phase(3'd0, n);
    check("gated_m_green", n, 3 * MIN);
    run_phase(3'd1, n);
    check("gated_m_yellow", n, 3 * YEL);
    run_phase(3'd2, n);
    check("gated_allred", n, 3 * AR);
    repeat (5) step();
    check("gated_in_c_green", {PHASE, COUNTRYLIGHT}, {3'd3, 2'b10});
    #2;
    do_reset();
    gated = 1'b0;

    for (int m = 0; m < 5; m++) begin
      for (int c = 0; c < 8; c++) begin
        MAIN_TRAFFIC = 3'(m);
        COUNTRY_TRAFFIC = 3'(c);
        repeat (60) step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
